// File: rtl/ahb_lite_defs.sv
// ----------------------------------------------------------------------------
// ahb_lite_defs : shared AHB-Lite field encodings and byte-lane helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ahb_lite_defs;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'b000,
        HSIZE_HALF   = 3'b001,
        HSIZE_WORD   = 3'b010,
        HSIZE_DWORD  = 3'b011,
        HSIZE_4WORD  = 3'b100,
        HSIZE_8WORD  = 3'b101,
        HSIZE_16WORD = 3'b110,
        HSIZE_32WORD = 3'b111
    } hsize_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    // Little-endian lane mask for a naturally aligned byte/half/word access.
    function automatic logic [3:0] lane_enables(input hsize_t size, input logic [1:0] lane);
        case (size)
            HSIZE_BYTE: return 4'b0001 << lane;
            HSIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_lite_sram_slave_if.sv
// ----------------------------------------------------------------------------
// ahb_lite_sram_slave_if : AHB-Lite bus bundle with master/slave views
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ahb_lite_sram_slave_if
    import ahb_lite_defs::*;
#(
    parameter int ADDR_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    hsize_t                HSIZE;
    hburst_t               HBURST;
    htrans_t               HTRANS;
    logic [3:0]            HPROT;
    logic                  HMASTLOCK;
    logic                  HREADY;
    logic [31:0]           HWDATA;
    logic [31:0]           HRDATA;
    logic                  HREADYOUT;
    hresp_t                HRESP;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HMASTLOCK,
               HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HMASTLOCK,
               HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

`default_nettype wire

// File: rtl/ahb_lite_sram_array.sv
// ----------------------------------------------------------------------------
// ahb_lite_sram_array : 32-bit RAM, per-byte write enables, async read
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ahb_lite_sram_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    // One byte-wide array per lane keeps every lane independently writable.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we[i]) begin
                mem[addr] <= wdata[8*i +: 8];
            end
        end

        assign rdata[8*i +: 8] = mem[addr];
    end

endmodule

`default_nettype wire

// File: rtl/ahb_lite_sram_slave.sv
// ----------------------------------------------------------------------------
// ahb_lite_sram_slave : AHB-Lite SRAM slave, programmable wait states, errors
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ahb_lite_sram_slave
    import ahb_lite_defs::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_lite_sram_slave_if.slave ahb
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-3:0] c_mem_depth = (ADDR_WIDTH-2)'(MEM_DEPTH);
    localparam logic [2:0]            c_wait_init = 3'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t           r_state;
    logic [2:0]       r_wait_cnt;
    logic             r_pending;
    logic             r_write;
    hsize_t           r_size;
    logic [1:0]       r_lane;
    logic [IDX_W-1:0] r_index;
    logic             r_readyout;
    hresp_t           r_resp;

    logic [ADDR_WIDTH-3:0] w_word_idx;
    logic                  w_accept;
    logic                  w_legal;
    logic                  w_complete;
    logic [3:0]            w_we;
    logic [31:0]           w_rdata;
    logic                  w_unused_ok;

    assign w_word_idx = ahb.HADDR[ADDR_WIDTH-1:2];
    assign w_accept   = ahb.HSEL && ahb.HREADY &&
                        (ahb.HTRANS == HTRANS_NONSEQ || ahb.HTRANS == HTRANS_SEQ);
    assign w_unused_ok = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK};

    always_comb begin
        w_legal = 1'b1;
        if (ahb.HSIZE > HSIZE_WORD)                               w_legal = 1'b0;
        if (ahb.HSIZE == HSIZE_HALF && ahb.HADDR[0])              w_legal = 1'b0;
        if (ahb.HSIZE == HSIZE_WORD && ahb.HADDR[1:0] != 2'b00)   w_legal = 1'b0;
        if (w_word_idx >= c_mem_depth)                            w_legal = 1'b0;
    end

    // A legal transfer completes in the first data-phase cycle with HREADYOUT high.
    assign w_complete = r_pending && r_readyout;
    assign w_we       = (w_complete && r_write) ? lane_enables(r_size, r_lane) : 4'b0000;
    assign ahb.HRDATA    = (w_complete && !r_write) ? w_rdata : 32'h0;
    assign ahb.HREADYOUT = r_readyout;
    assign ahb.HRESP     = r_resp;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 3'd0;
            r_pending  <= 1'b0;
            r_write    <= READ;
            r_size     <= HSIZE_BYTE;
            r_lane     <= 2'b00;
            r_index    <= '0;
            r_readyout <= 1'b1;
            r_resp     <= HRESP_OKAY;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_wait_cnt != 3'd0) begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end else begin
                        r_readyout <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_ERR1: begin
                    r_state    <= ST_ERR2;
                    r_readyout <= 1'b1;
                    r_resp     <= HRESP_ERROR;
                end
                default: begin
                    // IDLE and ERR2 both present HREADYOUT=1, so both may take a new address phase.
                    if (w_accept && w_legal) begin
                        r_pending <= 1'b1;
                        r_write   <= ahb.HWRITE;
                        r_size    <= ahb.HSIZE;
                        r_lane    <= ahb.HADDR[1:0];
                        r_index   <= w_word_idx[IDX_W-1:0];
                        r_resp    <= HRESP_OKAY;
                        if (WAIT_STATES > 0) begin
                            r_state    <= ST_WAIT;
                            r_readyout <= 1'b0;
                            r_wait_cnt <= c_wait_init;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_readyout <= 1'b1;
                        end
                    end else if (w_accept) begin
                        r_pending  <= 1'b0;
                        r_state    <= ST_ERR1;
                        r_readyout <= 1'b0;
                        r_resp     <= HRESP_ERROR;
                    end else begin
                        r_pending  <= 1'b0;
                        r_state    <= ST_IDLE;
                        r_readyout <= 1'b1;
                        r_resp     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    ahb_lite_sram_array #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (HCLK),
        .we    (w_we),
        .addr  (r_index),
        .wdata (ahb.HWDATA),
        .rdata (w_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_sram_slave.sv
// ----------------------------------------------------------------------------
// tb_ahb_lite_sram_slave : directed bench, zero-wait and two-wait instances
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ahb_lite_sram_slave;
    import ahb_lite_defs::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahb_lite_sram_slave_if #(.ADDR_WIDTH(32)) bus0 ();
    ahb_lite_sram_slave_if #(.ADDR_WIDTH(32)) bus2 ();

    logic        sel0, sel2, hwrite;
    logic [31:0] haddr, hwdata;
    hsize_t      hsize;
    htrans_t     htrans;

    assign bus0.HSEL = sel0;          assign bus2.HSEL = sel2;
    assign bus0.HADDR = haddr;        assign bus2.HADDR = haddr;
    assign bus0.HWRITE = hwrite;      assign bus2.HWRITE = hwrite;
    assign bus0.HSIZE = hsize;        assign bus2.HSIZE = hsize;
    assign bus0.HTRANS = htrans;      assign bus2.HTRANS = htrans;
    assign bus0.HWDATA = hwdata;      assign bus2.HWDATA = hwdata;
    assign bus0.HBURST = HBURST_SINGLE; assign bus2.HBURST = HBURST_INCR;
    assign bus0.HPROT = 4'b0011;      assign bus2.HPROT = 4'b0011;
    assign bus0.HMASTLOCK = 1'b0;     assign bus2.HMASTLOCK = 1'b0;
    assign bus0.HREADY = bus0.HREADYOUT;
    assign bus2.HREADY = bus2.HREADYOUT;

    ahb_lite_sram_slave #(.ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .ahb(bus0)
    );
    ahb_lite_sram_slave #(.ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) u_dut2 (
        .HCLK(clk), .HRESETn(rst_n), .ahb(bus2)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rd_first, rd_last;
    logic        resp_first, resp_last;
    int          lows;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic cur_ready(input bit which);
        return which ? bus2.HREADYOUT : bus0.HREADYOUT;
    endfunction
    function automatic logic cur_resp(input bit which);
        return which ? bus2.HRESP : bus0.HRESP;
    endfunction
    function automatic logic [31:0] cur_rdata(input bit which);
        return which ? bus2.HRDATA : bus0.HRDATA;
    endfunction

    // Single non-pipelined transfer; entered and left #1 after a rising edge.
    task automatic xfer(input bit which, input logic wr, input hsize_t sz,
                        input logic [31:0] addr, input logic [31:0] wd);
        sel0 = !which; sel2 = which;
        htrans = HTRANS_NONSEQ; haddr = addr; hwrite = wr; hsize = sz;
        @(posedge clk); #1;
        sel0 = 1'b0; sel2 = 1'b0; htrans = HTRANS_IDLE; hwdata = wd;
        lows = 0;
        @(negedge clk);
        resp_first = cur_resp(which);
        rd_first   = cur_rdata(which);
        while (!cur_ready(which) && lows < 20) begin
            lows++;
            @(negedge clk);
        end
        if (lows >= 20) check1("xfer_timeout", cur_ready(which), 1'b1);
        rd_last   = cur_rdata(which);
        resp_last = cur_resp(which);
        @(posedge clk); #1;
    endtask

    initial begin
        sel0 = 1'b0; sel2 = 1'b0; hwrite = READ; haddr = 32'h0; hwdata = 32'h0;
        hsize = HSIZE_WORD; htrans = HTRANS_IDLE;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check1 ("rst_ready0", bus0.HREADYOUT, 1'b1);
        check1 ("rst_resp0",  bus0.HRESP,     1'b0);
        check32("rst_rdata0", bus0.HRDATA,    32'h0);
        check1 ("rst_ready2", bus2.HREADYOUT, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait word write then read
        xfer(1'b0, WRITE, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
        check32("wr_db_lows", lows, 0);
        check1 ("wr_db_resp", resp_last, 1'b0);
        xfer(1'b0, READ, HSIZE_WORD, 32'h10, 32'h0);
        check32("rd_db_data", rd_last, 32'hDEADBEEF);
        check32("rd_db_lows", lows, 0);
        check1 ("rd_db_resp", resp_last, 1'b0);

        // Sub-word writes only touch their lanes
        xfer(1'b0, WRITE, HSIZE_WORD, 32'h10, 32'h11223344);
        xfer(1'b0, WRITE, HSIZE_BYTE, 32'h13, 32'hAA556677);
        xfer(1'b0, READ,  HSIZE_WORD, 32'h10, 32'h0);
        check32("rd_byte_merge", rd_last, 32'hAA223344);
        xfer(1'b0, WRITE, HSIZE_HALF, 32'h12, 32'hBEEF9999);
        xfer(1'b0, READ,  HSIZE_BYTE, 32'h11, 32'h0);
        check32("rd_half_merge", rd_last, 32'hBEEF3344);

        // Illegal transfers: two-cycle error response, memory untouched
        xfer(1'b0, WRITE, HSIZE_WORD, 32'h00, 32'h01020304);
        xfer(1'b0, WRITE, HSIZE_WORD, 32'h02, 32'hFFFFFFFF);
        check32("err_wmis_lows", lows, 1);
        check1 ("err_wmis_resp1", resp_first, 1'b1);
        check1 ("err_wmis_resp2", resp_last, 1'b1);
        xfer(1'b0, WRITE, HSIZE_HALF, 32'h01, 32'hFFFFFFFF);
        check1 ("err_hmis_resp", resp_last, 1'b1);
        check32("err_hmis_lows", lows, 1);
        xfer(1'b0, WRITE, HSIZE_WORD, 32'h1000, 32'hFFFFFFFF);
        check1 ("err_range_resp", resp_last, 1'b1);
        xfer(1'b0, WRITE, HSIZE_DWORD, 32'h00, 32'hFFFFFFFF);
        check1 ("err_size_resp", resp_last, 1'b1);
        xfer(1'b0, READ, HSIZE_WORD, 32'h02, 32'h0);
        check32("err_rd_lows", lows, 1);
        check1 ("err_rd_resp1", resp_first, 1'b1);
        check1 ("err_rd_resp2", resp_last, 1'b1);
        check32("err_rd_data1", rd_first, 32'h0);
        check32("err_rd_data2", rd_last, 32'h0);
        xfer(1'b0, READ, HSIZE_WORD, 32'h00, 32'h0);
        check32("err_mem_kept", rd_last, 32'h01020304);
        check1 ("err_after_ok", resp_last, 1'b0);

        // Back-to-back write then read of the same word
        sel0 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h20; hwrite = WRITE; hsize = HSIZE_WORD;
        @(posedge clk); #1;
        hwdata = 32'h55AA55AA; haddr = 32'h20; hwrite = READ;
        @(negedge clk);
        check1("b2b_wr_ready", bus0.HREADYOUT, 1'b1);
        @(posedge clk); #1;
        sel0 = 1'b0; htrans = HTRANS_IDLE;
        @(negedge clk);
        check32("b2b_rd_data", bus0.HRDATA, 32'h55AA55AA);
        check1 ("b2b_rd_resp", bus0.HRESP, 1'b0);
        @(posedge clk); #1;

        // Selected BUSY write: zero-wait OKAY, no memory access
        sel0 = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h20; hwrite = WRITE; hsize = HSIZE_WORD;
        @(posedge clk); #1;
        sel0 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFFFFFF;
        @(negedge clk);
        check1 ("busy_ready", bus0.HREADYOUT, 1'b1);
        check1 ("busy_resp",  bus0.HRESP,     1'b0);
        check32("busy_rdata", bus0.HRDATA,    32'h0);
        @(posedge clk); #1;
        xfer(1'b0, READ, HSIZE_WORD, 32'h20, 32'h0);
        check32("busy_mem_kept", rd_last, 32'h55AA55AA);

        // Two wait states
        xfer(1'b1, WRITE, HSIZE_WORD, 32'h40, 32'hCAFEF00D);
        check32("ws2_wr_lows", lows, 2);
        check1 ("ws2_wr_resp", resp_last, 1'b0);
        xfer(1'b1, READ, HSIZE_WORD, 32'h40, 32'h0);
        check32("ws2_rd_lows", lows, 2);
        check32("ws2_rd_wait_data", rd_first, 32'h0);
        check32("ws2_rd_data", rd_last, 32'hCAFEF00D);
        check1 ("ws2_rd_resp", resp_last, 1'b0);

        // Reset during the wait of a write aborts it
        sel2 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h40; hwrite = WRITE; hsize = HSIZE_WORD;
        @(posedge clk); #1;
        sel2 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h12345678;
        @(negedge clk);
        check1("rstw_waiting", bus2.HREADYOUT, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check1("rstw_ready", bus2.HREADYOUT, 1'b1);
        check1("rstw_resp",  bus2.HRESP,     1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1'b1, READ, HSIZE_WORD, 32'h40, 32'h0);
        check32("rstw_mem_kept", rd_last, 32'hCAFEF00D);
        check32("rstw_rd_lows", lows, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
